// File: rtl/logic_gates.sv
// logic_gates: registered two-input bitwise gate unit.
//
// Each enabled rising edge of iClk captures AND, OR, NOT(A), NAND, NOR, XOR
// and XNOR of the current operands. Every output is a flop, so latency is
// exactly one edge and no combinational path runs from inputs to outputs.
//
// Ports:
//   iClk    - system clock, rising-edge active
//   iRst_n  - asynchronous active-low reset; clears all outputs to 0
//   iEn     - sample enable; 1 = capture new results this edge
//   iA, iB  - WIDTH-bit operands (oNot uses iA only)
//   oAnd .. oXnor - registered gate results, WIDTH bits each
//   oValid  - sticky flag: outputs hold a result captured since reset
//
// Reset values are all 0, even for gates whose function of (0,0) is 1;
// consumers must qualify the gate outputs with oValid.

module logic_gates #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [WIDTH-1:0] oNand,
  output logic [WIDTH-1:0] oNor,
  output logic [WIDTH-1:0] oXor,
  output logic [WIDTH-1:0] oXnor,
  output logic             oValid
);

  logic [WIDTH-1:0] and_d,  and_q;
  logic [WIDTH-1:0] or_d,   or_q;
  logic [WIDTH-1:0] not_d,  not_q;
  logic [WIDTH-1:0] nand_d, nand_q;
  logic [WIDTH-1:0] nor_d,  nor_q;
  logic [WIDTH-1:0] xor_d,  xor_q;
  logic [WIDTH-1:0] xnor_d, xnor_q;
  logic             valid_d, valid_q;

  // Hold by default; the enable alone decides whether inputs are looked at,
  // so unknown operands while disabled never reach the registers.
  always_comb begin
    and_d   = and_q;
    or_d    = or_q;
    not_d   = not_q;
    nand_d  = nand_q;
    nor_d   = nor_q;
    xor_d   = xor_q;
    xnor_d  = xnor_q;
    valid_d = valid_q;
    if (iEn) begin
      and_d   = iA & iB;
      or_d    = iA | iB;
      not_d   = ~iA;
      nand_d  = ~(iA & iB);
      nor_d   = ~(iA | iB);
      xor_d   = iA ^ iB;
      xnor_d  = ~(iA ^ iB);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      and_q   <= '0;
      or_q    <= '0;
      not_q   <= '0;
      nand_q  <= '0;
      nor_q   <= '0;
      xor_q   <= '0;
      xnor_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      and_q   <= and_d;
      or_q    <= or_d;
      not_q   <= not_d;
      nand_q  <= nand_d;
      nor_q   <= nor_d;
      xor_q   <= xor_d;
      xnor_q  <= xnor_d;
      valid_q <= valid_d;
    end
  end

  assign oAnd   = and_q;
  assign oOr    = or_q;
  assign oNot   = not_q;
  assign oNand  = nand_q;
  assign oNor   = nor_q;
  assign oXor   = xor_q;
  assign oXnor  = xnor_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_logic_gates.sv
// tb_logic_gates: self-checking bench for logic_gates, WIDTH=1 and WIDTH=8
// instances sharing clock, reset and enable. Expected register contents are
// pushed to per-instance queues when stimulus is driven and popped one edge
// later for comparison.

module tb_logic_gates;

  typedef struct packed {
    logic [7:0] g_and;
    logic [7:0] g_or;
    logic [7:0] g_not;
    logic [7:0] g_nand;
    logic [7:0] g_nor;
    logic [7:0] g_xor;
    logic [7:0] g_xnor;
    logic       valid;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic [0:0] and1, or1, not1, nand1, nor1, xor1, xnor1;
  logic       val1;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
  logic       val8;

  res_t obs1, obs8;
  res_t m1, m8, e1, e8;
  res_t q1[$];
  res_t q8[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_gates #(.WIDTH(1)) u_dut1 (
    .iClk(clk), .iRst_n(rst_n), .iEn(en), .iA(a1), .iB(b1),
    .oAnd(and1), .oOr(or1), .oNot(not1), .oNand(nand1), .oNor(nor1),
    .oXor(xor1), .oXnor(xnor1), .oValid(val1)
  );

  logic_gates #(.WIDTH(8)) u_dut8 (
    .iClk(clk), .iRst_n(rst_n), .iEn(en), .iA(a8), .iB(b8),
    .oAnd(and8), .oOr(or8), .oNot(not8), .oNand(nand8), .oNor(nor8),
    .oXor(xor8), .oXnor(xnor8), .oValid(val8)
  );

  assign obs1 = {7'b0, and1, 7'b0, or1, 7'b0, not1, 7'b0, nand1,
                 7'b0, nor1, 7'b0, xor1, 7'b0, xnor1, val1};
  assign obs8 = {and8, or8, not8, nand8, nor8, xor8, xnor8, val8};

  function automatic res_t calc(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] mask);
    res_t r;
    r.g_and  = (a & b) & mask;
    r.g_or   = (a | b) & mask;
    r.g_not  = (~a) & mask;
    r.g_nand = (~(a & b)) & mask;
    r.g_nor  = (~(a | b)) & mask;
    r.g_xor  = (a ^ b) & mask;
    r.g_xnor = (~(a ^ b)) & mask;
    r.valid  = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic [0:0] na1, input logic [0:0] nb1,
                       input logic [7:0] na8, input logic [7:0] nb8,
                       input logic nen);
    a1 = na1; b1 = nb1; a8 = na8; b8 = nb8; en = nen;
    if (!rst_n) begin
      m1 = '0;
      m8 = '0;
    end else if (nen) begin
      m1 = calc({7'b0, na1}, {7'b0, nb1}, 8'h01);
      m8 = calc(na8, nb8, 8'hFF);
    end
    q1.push_back(m1);
    q8.push_back(m8);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (q1.size() == 0 || q8.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty q1=%0d q8=%0d", q1.size(), q8.size());
      e1 = '0; e8 = '0;
    end else begin
      e1 = q1.pop_front();
      e8 = q8.pop_front();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    m1 = '0; m8 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    tick;
    checks++; if (obs1 !== e1) begin errors++; $display("FAIL rst_pre_w1 got=%h exp=%h", obs1, e1); end
    checks++; if (obs8 !== e8) begin errors++; $display("FAIL rst_pre_w8 got=%h exp=%h", obs8, e8); end
    // Assert reset mid-cycle with inputs still enabled
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs1 !== res_t'(0)) begin errors++; $display("FAIL rst_async_w1 got=%h exp=0", obs1); end
    checks++; if (obs8 !== res_t'(0)) begin errors++; $display("FAIL rst_async_w8 got=%h exp=0", obs8); end
    q1.delete(); q8.delete();
    m1 = '0; m8 = '0;
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    tick;
    checks++; if (obs1 !== e1) begin errors++; $display("FAIL rst_held_w1 got=%h exp=%h", obs1, e1); end
    checks++; if (obs8 !== e8) begin errors++; $display("FAIL rst_held_w8 got=%h exp=%h", obs8, e8); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick;
      checks++; if (obs1 !== e1) begin errors++; $display("FAIL rst_idle_w1 got=%h exp=%h", obs1, e1); end
      checks++; if (obs8 !== e8) begin errors++; $display("FAIL rst_idle_w8 got=%h exp=%h", obs8, e8); end
      checks++; if (val1 !== 1'b0 || val8 !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got=%b%b exp=00", val1, val8); end
    end
  endtask

  task automatic test_truth_table;
    logic [1:0] pairs [5];
    logic [6:0] tt    [5];
    // bit order: and, or, not, nand, nor, xor, xnor
    pairs[0] = 2'b00; tt[0] = 7'b0011101;
    pairs[1] = 2'b10; tt[1] = 7'b0101010;
    pairs[2] = 2'b01; tt[2] = 7'b0111010;
    pairs[3] = 2'b11; tt[3] = 7'b1100001;
    pairs[4] = 2'b00; tt[4] = 7'b0011101;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        drive(pairs[i][1], pairs[i][0], {8{pairs[i][1]}}, {8{pairs[i][0]}}, 1'b1);
        tick;
        checks++; if (obs1 !== e1) begin errors++; $display("FAIL tt_w1 pair=%0d got=%h exp=%h", i, obs1, e1); end
        checks++; if (obs8 !== e8) begin errors++; $display("FAIL tt_w8 pair=%0d got=%h exp=%h", i, obs8, e8); end
        if (k == 0) begin
          checks++;
          if ({and1, or1, not1, nand1, nor1, xor1, xnor1, val1} !== {tt[i], 1'b1}) begin
            errors++;
            $display("FAIL tt_table pair=%0d got=%b exp=%b", i,
                     {and1, or1, not1, nand1, nor1, xor1, xnor1, val1}, {tt[i], 1'b1});
          end
        end
      end
    end
  endtask

  task automatic test_latency;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick;
    checks++; if (obs1 !== e1) begin errors++; $display("FAIL lat_base got=%h exp=%h", obs1, e1); end
    drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
    #3;
    checks++; if (obs1 !== e1 || obs8 !== e8) begin errors++; $display("FAIL lat_early got=%h exp=%h", obs1, e1); end
    tick;
    checks++; if (obs1 !== e1) begin errors++; $display("FAIL lat_update got=%h exp=%h", obs1, e1); end
    checks++; if (not1 !== 1'b0 || or1 !== 1'b1) begin errors++; $display("FAIL lat_vals got=not%b/or%b exp=not0/or1", not1, or1); end
  endtask

  task automatic test_enable_hold;
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    tick;
    checks++; if (obs1 !== e1) begin errors++; $display("FAIL hold_cap got=%h exp=%h", obs1, e1); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick;
      checks++; if (obs8 !== e8) begin errors++; $display("FAIL hold_w8 got=%h exp=%h", obs8, e8); end
      checks++;
      if (and1 !== 1'b1 || not1 !== 1'b0 || val1 !== 1'b1) begin
        errors++;
        $display("FAIL hold_w1 got=and%b/not%b/v%b exp=and1/not0/v1", and1, not1, val1);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick;
    checks++; if (and1 !== 1'b0 || not1 !== 1'b1) begin errors++; $display("FAIL hold_release got=and%b/not%b exp=and0/not1", and1, not1); end
    checks++; if (obs8 !== e8) begin errors++; $display("FAIL hold_release_w8 got=%h exp=%h", obs8, e8); end
  endtask

  task automatic test_x_inputs;
    for (int i = 0; i < 3; i++) begin
      drive(1'bx, 1'bz, 8'hxx, 8'hzz, 1'b0);
      tick;
      checks++; if (obs1 !== e1) begin errors++; $display("FAIL xin_w1 got=%h exp=%h", obs1, e1); end
      checks++; if (obs8 !== e8) begin errors++; $display("FAIL xin_w8 got=%h exp=%h", obs8, e8); end
    end
  endtask

  task automatic test_wide;
    drive(1'b0, 1'b1, 8'hF0, 8'hAA, 1'b1);
    tick;
    checks++;
    if (obs8 !== {8'hA0, 8'hFA, 8'h0F, 8'h5F, 8'h05, 8'h5A, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL wide_const got=%h exp=%h", obs8,
               {8'hA0, 8'hFA, 8'h0F, 8'h5F, 8'h05, 8'h5A, 8'hA5, 1'b1});
    end
    checks++; if (obs8 !== e8) begin errors++; $display("FAIL wide_model got=%h exp=%h", obs8, e8); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      tick;
      checks++; if (obs1 !== e1) begin errors++; $display("FAIL rnd_w1 i=%0d got=%h exp=%h", i, obs1, e1); end
      checks++; if (obs8 !== e8) begin errors++; $display("FAIL rnd_w8 i=%0d got=%h exp=%h", i, obs8, e8); end
      if (val8 === 1'b1) begin
        checks++;
        if (nand8 !== ~and8 || nor8 !== ~or8 || xnor8 !== ~xor8 || xor8 !== (or8 & nand8)) begin
          errors++;
          $display("FAIL rnd_invariant i=%0d got=and%h/or%h/nand%h/nor%h/xor%h/xnor%h", i,
                   and8, or8, nand8, nor8, xor8, xnor8);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_truth_table;
    test_latency;
    test_enable_hold;
    test_x_inputs;
    test_wide;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
